// File: rtl/cfu_bus_pkg.sv
// Shared widths and bus payload types for the CFU command/response pipeline.
package cfu_bus_pkg;

   localparam int unsigned FUNC_ID_W = 3;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CMD_DEPTH = 2;

   typedef struct packed {
      logic [FUNC_ID_W-1:0] function_id;
      logic [DATA_W-1:0]    inputs_0;
      logic [DATA_W-1:0]    inputs_1;
   } cfu_cmd_t;

   typedef struct packed {
      logic              response_ok;
      logic [DATA_W-1:0] outputs_0;
   } cfu_rsp_t;

   localparam int unsigned CMD_W = $bits(cfu_cmd_t);
   localparam int unsigned RSP_W = $bits(cfu_rsp_t);

endpackage

// File: rtl/cfu_bus_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of 2.
// Caller guarantees no push when full and no pop when empty.
module cfu_bus_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage, pointers (wrap naturally) and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push && pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cfu_bus_pipe.sv
// Registered cmd/rsp pipeline between the CPU CFU bus master and the Cfu.
// Optional build macro: CFU_BUS_PIPE_PERF_EN adds issue/stall counters.
module cfu_bus_pipe
   import cfu_bus_pkg::*;
#(
   parameter int unsigned RSP_DEPTH = 2,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_cmd_valid,
   output logic                 cpu_cmd_ready,
   input  logic [FUNC_ID_W-1:0] cpu_cmd_payload_function_id,
   input  logic [DATA_W-1:0]    cpu_cmd_payload_inputs_0,
   input  logic [DATA_W-1:0]    cpu_cmd_payload_inputs_1,
   output logic                 cpu_rsp_valid,
   input  logic                 cpu_rsp_ready,
   output logic                 cpu_rsp_payload_response_ok,
   output logic [DATA_W-1:0]    cpu_rsp_payload_outputs_0,
   output logic                 cfu_cmd_valid,
   input  logic                 cfu_cmd_ready,
   output logic [FUNC_ID_W-1:0] cfu_cmd_payload_function_id,
   output logic [DATA_W-1:0]    cfu_cmd_payload_inputs_0,
   output logic [DATA_W-1:0]    cfu_cmd_payload_inputs_1,
   input  logic                 cfu_rsp_valid,
   output logic                 cfu_rsp_ready,
   input  logic                 cfu_rsp_payload_response_ok,
   input  logic [DATA_W-1:0]    cfu_rsp_payload_outputs_0,
   output logic                 err_orphan_rsp
`ifdef CFU_BUS_PIPE_PERF_EN
   ,
   output logic [31:0]          perf_cmd_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);

   localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH + 1);
   localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned OUT_W     = $clog2(MAX_OUTST + 1);
   localparam int unsigned SUM_W     = ((OUT_W > RSP_CNT_W) ? OUT_W : RSP_CNT_W) + 1;

   cfu_cmd_t             cmd_in;
   cfu_cmd_t             cmd_head;
   logic [CMD_CNT_W-1:0] cmd_count;
   cfu_rsp_t             rsp_in;
   cfu_rsp_t             rsp_head;
   logic [RSP_CNT_W-1:0] rsp_count;
   logic [OUT_W-1:0]     outst_q;
   logic [SUM_W-1:0]     credit_used;
   logic                 err_q;
   logic                 issue_ok;
   logic                 cmd_push;
   logic                 cmd_fire;
   logic                 rsp_fire;
   logic                 orphan;
   logic                 rsp_pop;

   assign cmd_in = '{function_id: cpu_cmd_payload_function_id,
                     inputs_0:    cpu_cmd_payload_inputs_0,
                     inputs_1:    cpu_cmd_payload_inputs_1};
   assign rsp_in = '{response_ok: cfu_rsp_payload_response_ok,
                     outputs_0:   cfu_rsp_payload_outputs_0};

   // Issue credit uses registered state only: FIFO slots already claimed
   // by buffered responses plus commands still inside the Cfu.
   always_comb begin
      credit_used = SUM_W'(rsp_count) + SUM_W'(outst_q);
      issue_ok    = (cmd_count != '0) &&
                    (credit_used < SUM_W'(RSP_DEPTH)) &&
                    (outst_q < OUT_W'(MAX_OUTST));
   end

   // Port drive; everything is held quiet and zero while reset is high.
   always_comb begin
      cpu_cmd_ready               = 1'b0;
      cfu_cmd_valid               = 1'b0;
      cpu_rsp_valid               = 1'b0;
      err_orphan_rsp              = 1'b0;
      cfu_cmd_payload_function_id = '0;
      cfu_cmd_payload_inputs_0    = '0;
      cfu_cmd_payload_inputs_1    = '0;
      cpu_rsp_payload_response_ok = 1'b0;
      cpu_rsp_payload_outputs_0   = '0;
      if (!reset) begin
         cpu_cmd_ready               = (cmd_count < CMD_CNT_W'(CMD_DEPTH));
         cfu_cmd_valid               = issue_ok;
         cpu_rsp_valid               = (rsp_count != '0);
         err_orphan_rsp              = err_q;
         cfu_cmd_payload_function_id = cmd_head.function_id;
         cfu_cmd_payload_inputs_0    = cmd_head.inputs_0;
         cfu_cmd_payload_inputs_1    = cmd_head.inputs_1;
         cpu_rsp_payload_response_ok = rsp_head.response_ok;
         cpu_rsp_payload_outputs_0   = rsp_head.outputs_0;
      end
   end

   // Handshakes; a response in the same cycle as its command is legal.
   always_comb begin
      cmd_push = cpu_cmd_valid && cpu_cmd_ready;
      cmd_fire = cfu_cmd_valid && cfu_cmd_ready;
      orphan   = !reset && cfu_rsp_valid && (outst_q == '0) && !cmd_fire;
      rsp_fire = !reset && cfu_rsp_valid && cfu_rsp_ready && !orphan;
      rsp_pop  = cpu_rsp_valid && cpu_rsp_ready;
   end

   assign cfu_rsp_ready = 1'b1;

   // In-flight command count and sticky orphan-response flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (cmd_fire && !rsp_fire) begin
            outst_q <= outst_q + OUT_W'(1);
         end else if (!cmd_fire && rsp_fire) begin
            outst_q <= outst_q - OUT_W'(1);
         end
         if (orphan) begin
            err_q <= 1'b1;
         end
      end
   end

   cfu_bus_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_skid (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_push),
      .wdata (cmd_in),
      .pop   (cmd_fire),
      .rdata (cmd_head),
      .count (cmd_count)
   );

   cfu_bus_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rsp_fire),
      .wdata (rsp_in),
      .pop   (rsp_pop),
      .rdata (rsp_head),
      .count (rsp_count)
   );

`ifdef CFU_BUS_PIPE_PERF_EN
   // Issue and stall counters, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cmd_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (cmd_fire) begin
            perf_cmd_cnt <= perf_cmd_cnt + 32'(1);
         end
         if ((cmd_count != '0) && !cfu_cmd_valid) begin
            perf_stall_cnt <= perf_stall_cnt + 32'(1);
         end
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: doc/cfu_bus_pipe.md
Name: cfu_bus_pipe

Overview:
Registered command/response pipeline between the CPU's CFU bus master and the combinational Cfu. It breaks the CPU-to-CFU timing path with a 2-entry command skid buffer and an in-order response FIFO, using credit-based issue so responses are never lost. Both sides use the same valid/ready cmd/rsp bus as the Cfu; the downstream side connects port-for-port to the Cfu's io_bus_* ports.

Parameters:
RSP_DEPTH, 2, response FIFO entries; power of 2, >=2
MAX_OUTST, 4, maximum commands issued to the CFU without a returned response (counter width clog2(MAX_OUTST+1))

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high
cpu_cmd_valid  in  1  command from CPU
cpu_cmd_ready  out  1  pipe can accept a command
cpu_cmd_payload_function_id  in  3  function select
cpu_cmd_payload_inputs_0  in  32  operand 0
cpu_cmd_payload_inputs_1  in  32  operand 1
cpu_rsp_valid  out  1  response to CPU available
cpu_rsp_ready  in  1  CPU takes response
cpu_rsp_payload_response_ok  out  1  ok flag from CFU
cpu_rsp_payload_outputs_0  out  32  result
cfu_cmd_valid  out  1  to Cfu io_bus_cmd_valid
cfu_cmd_ready  in  1  from Cfu io_bus_cmd_ready
cfu_cmd_payload_function_id  out  3  to Cfu
cfu_cmd_payload_inputs_0  out  32  to Cfu
cfu_cmd_payload_inputs_1  out  32  to Cfu
cfu_rsp_valid  in  1  from Cfu io_bus_rsp_valid
cfu_rsp_ready  out  1  to Cfu io_bus_rsp_ready
cfu_rsp_payload_response_ok  in  1  from Cfu
cfu_rsp_payload_outputs_0  in  32  from Cfu
err_orphan_rsp  out  1  sticky: response seen with nothing in flight

Behaviour:
- Reset (sync, active-high): all counters, pointers, and payload registers cleared. While reset is high: cpu_cmd_ready=0, cpu_rsp_valid=0, cfu_cmd_valid=0, err_orphan_rsp=0, payload outputs=0. Reset mid-operation discards all buffered commands and responses.
- Cmd skid: 2 entries, FIFO order. cpu_cmd_ready = (cmd_count<2), decoded from registers only. Push on cpu_cmd_valid&&cpu_cmd_ready. Push and pop in the same cycle leave cmd_count unchanged.
- Issue: cfu_cmd_valid = cmd_count>0 && (rsp_count+outst) < RSP_DEPTH && outst < MAX_OUTST. Registered values only, so a same-cycle CPU pop does not add credit. Payload is the skid head. Pop on cfu_cmd_valid&&cfu_cmd_ready.
- cfu_rsp_ready = 1 constantly; credit guarantees FIFO space.
- outst_next = outst + cmd_fire - rsp_fire. A response in the same cycle as its command, which is the combinational-Cfu case, is legal.
- Orphan: cfu_rsp_valid while outst==0 and no cmd_fire that cycle → response dropped, err_orphan_rsp set until reset.
- Rsp FIFO: RSP_DEPTH entries of {ok,data[31:0]}, pointers wrap modulo RSP_DEPTH. cpu_rsp_valid = rsp_count>0; payload is FIFO head, registered. Pop on cpu_rsp_valid&&cpu_rsp_ready. Push and pop in the same cycle leave rsp_count unchanged.
- Latency with the combinational Cfu: command accepted at cycle T, issued at T+1, cpu_rsp_valid at T+2. Full-rate sustained throughput is 1 op/cycle with cpu_rsp_ready held high.
- Strict in-order: responses return in command order. Payload is unchanged while cpu_rsp_valid=1 and cpu_rsp_ready=0.

Optional Feature:
CFU_BUS_PIPE_PERF_EN
- Defined: adds outputs perf_cmd_cnt[31:0] (commands issued to the CFU) and perf_stall_cnt[31:0] (cycles with cmd_count>0 && !cfu_cmd_valid). Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cfu_bus_pkg: FUNC_ID_W=3, DATA_W=32, cmd payload struct {function_id, inputs_0, inputs_1}, rsp payload struct {response_ok, outputs_0}.
- One sub-module, cfu_bus_fifo: parameterised sync FIFO (width, depth) with count output. Instantiated twice: depth 2 for the cmd skid and RSP_DEPTH for responses.

Test Plan:
- Single op: fid=0, in0=0x01020304, in1=0x10203040 with a Cfu model → cpu_rsp_valid at T+2, outputs_0=0x000000AA, ok=1.
- Back-to-back stream: 8 commands with fid cycling 0/1/2, cpu_rsp_ready=1 → 8 in-order responses, e.g. fid=1 with in0=0x11223344 gives 0x44332211; no bubbles after the first.
- Backpressure: cpu_rsp_ready=0, send 6 cmds → cfu_cmd_valid stops after 2 issues (RSP_DEPTH=2), cpu_cmd_ready drops after skid full; release → all 6 correct, none lost.
- Multi-cycle Cfu model (rsp 3 cycles after cmd) → outst never exceeds MAX_OUTST=4; order preserved.
- Orphan: inject cfu_rsp_valid with nothing in flight → err_orphan_rsp=1, FIFO count unchanged, flag clears only on reset.
- Reset with 2 cmds and 1 rsp buffered → next cycle all valids 0; a fresh cmd returns a correct result at T+2.
